// File: rtl/pe_config_loader.sv
// rtl/pe_config_loader.sv - buffers tagged config words and streams whole packets to PE configure ports
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   cfg_wr_*         host write port: valid/ready handshake, target pe, data word, packet last marker
//   load_en          allows new packets to start (never pauses a packet in flight)
//   cfg_out          NUM_PE slices of 33 bits {valid, word}, one per PE_Configure_Inport
//   busy             sequencer not idle
//   cfg_done         one-cycle pulse in the idle gap after the last buffered packet drains
//   err              sticky: bad target PE or full FIFO with no complete packet

module pe_config_loader #(
    parameter int NUM_PE  = 2,
    parameter int PE_ID_W = 1,
    parameter int DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_wr_valid,
    output logic                  cfg_wr_ready,
    input  logic [PE_ID_W-1:0]    cfg_wr_pe,
    input  logic [31:0]           cfg_wr_data,
    input  logic                  cfg_wr_last,
    input  logic                  load_en,
    output logic [NUM_PE*33-1:0]  cfg_out,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Entry layout: {pe, last, token_valid, data}; the token bit lets the
    // stored word be forwarded as an output token without reassembly.
    localparam int EW = 34 + PE_ID_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // The state names what cfg_out shows during the cycle: STREAM shows a
    // packet word, GAP shows the single zero word that follows each packet.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [EW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count, pkt_cnt;
    logic [PE_ID_W-1:0]   tgt;
    logic                 last_q;   // word currently on cfg_out closes its packet

    logic [EW-1:0]        head;
    logic [PE_ID_W-1:0]   head_pe;
    logic                 head_last;
    logic [PE_ID_W-1:0]   sel_pe;
    int                   sel_idx;
    logic                 push, pop, first, start_ok, bad_pe;
    logic [NUM_PE*33-1:0] out_nx;

    assign head      = mem[rd_ptr];
    assign head_pe   = head[EW-1 -: PE_ID_W];
    assign head_last = head[33];

    assign cfg_wr_ready = (count < DEPTH_C);
    assign push         = cfg_wr_valid && cfg_wr_ready;
    assign start_ok     = load_en && (pkt_cnt != '0);

    assign busy     = (state != IDLE);
    assign cfg_done = (state == GAP) && (count == '0) && (pkt_cnt == '0);

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        first    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    pop      = 1'b1;
                    first    = 1'b1;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                // A packet only starts once its last word is buffered, so
                // the FIFO cannot run dry before last_q is seen.
                if (last_q) begin
                    state_nx = GAP;
                end else begin
                    pop      = 1'b1;
                    state_nx = STREAM;
                end
            end
            GAP: begin
                if (start_ok) begin
                    pop      = 1'b1;
                    first    = 1'b1;
                    state_nx = STREAM;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sel_pe  = first ? head_pe : tgt;
        sel_idx = int'(sel_pe);
        out_nx  = '0;
        // An out-of-range target matches no slice, so that packet drains
        // silently with every slice held at zero.
        for (int p = 0; p < NUM_PE; p++) begin
            if (pop && (sel_idx == p)) begin
                out_nx[33*p +: 33] = head[32:0];
            end
        end
        bad_pe = pop && first && (int'(head_pe) >= NUM_PE);
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cfg_wr_pe, cfg_wr_last, 1'b1, cfg_wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pkt_cnt <= '0;
            tgt     <= '0;
            last_q  <= 1'b0;
            err     <= 1'b0;
            cfg_out <= '0;
        end else begin
            state   <= state_nx;
            cfg_out <= out_nx;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= head_last;
                if (first) begin
                    tgt <= head_pe;
                end
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case ({push && cfg_wr_last, pop && head_last})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase

            // A full FIFO with no complete packet can never drain.
            if (bad_pe || ((count == DEPTH_C) && (pkt_cnt == '0))) begin
                err <= 1'b1;
            end
        end
    end

endmodule
